ab_pair_packer: RTL and testbench

// - Upstream feeder for the ab-struct consumer (subtest): packs a valid/ready byte stream into l2_pkg::ab pairs.
// - First byte of a pair goes to .a, second to .b; a frame ending on an odd byte is padded.
// - Packed pairs are buffered in a small FIFO before the ab output port.

---
 rtl/ab_pair_packer_pkg.sv | 17 +
 rtl/ab_pair_packer_fifo.sv | 33 +++
 rtl/ab_pair_packer.sv | 72 +++++++
 tb/tb_ab_pair_packer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ab_pair_packer_pkg.sv
// l2_pkg: shared ab pair type and packer FIFO entry; parity field exists only with AB_PACKER_PARITY_EN.
package l2_pkg;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } ab;
  typedef enum logic {ST_A, ST_B} pack_st_e;
  typedef struct packed {
    ab    pair;
    logic pad;
    logic last;
`ifdef AB_PACKER_PARITY_EN
    logic [1:0] par;
`endif
  } ab_entry_t;
  localparam ab AB_ZERO = '{a: 8'h00, b: 8'h00};
endpackage

// File: rtl/ab_pair_packer_fifo.sv
// ab_pair_fifo: sync FIFO with wrap-bit pointers; head reads as zero while empty.
module ab_pair_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [17:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   wdata,
  input  logic                     pop,
  output entry_t                   rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  entry_t mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wdata;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign level = wp - rp;
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];
endmodule

// File: rtl/ab_pair_packer.sv
// ab_pair_packer: packs a byte stream into l2_pkg::ab pairs, padding odd frames, through a small FIFO.
// Optional out_par port when AB_PACKER_PARITY_EN is defined.
module ab_pair_packer
  import l2_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_ab,
  output logic                   out_pad,
  output logic                   out_last,
`ifdef AB_PACKER_PARITY_EN
  output logic [1:0]             out_par,
`endif
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;
  pack_st_e st, st_nxt;
  logic [7:0] a_q;
  ab_entry_t ent, head;
  logic acc, push, pop, full, empty;
  logic [LW-1:0] lvl_nxt;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_comb begin
    st_nxt = st;
    push = 1'b0;
    ent = '0;
    ent.pair.a = st == ST_A ? in_data : a_q;
    ent.pair.b = st == ST_A ? PAD_BYTE : in_data;
    ent.pad = st == ST_A;
    ent.last = in_last;
`ifdef AB_PACKER_PARITY_EN
    ent.par = {^ent.pair.b, ^ent.pair.a};
`endif
    if (acc) begin
      push = st == ST_B || in_last;
      st_nxt = (st == ST_A && !in_last) ? ST_B : ST_A;
    end
  end
  // in_ready is registered from the post-edge occupancy so a push can never overflow
  assign lvl_nxt = level + LW'(push) - LW'(pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= ST_A;
      a_q <= '0;
      in_ready <= 1'b0;
    end else begin
      st <= st_nxt;
      if (acc && st == ST_A) a_q <= in_data;
      in_ready <= lvl_nxt != LW'(DEPTH);
    end
  ab_pair_fifo #(.DEPTH(DEPTH), .entry_t(ab_entry_t)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .wdata(ent), .pop(pop),
    .rdata(head), .level(level), .full(full), .empty(empty)
  );
  assign out_valid = !empty;
  assign out_ab    = head.pair;
  assign out_pad   = head.pad;
  assign out_last  = head.last;
`ifdef AB_PACKER_PARITY_EN
  assign out_par   = head.par;
`endif
endmodule

// File: tb/tb_ab_pair_packer.sv
// tb_ab_pair_packer: table-driven frames plus scoreboard checks of fill, wrap and mid-frame reset.
module tb_ab_pair_packer;
  localparam int DEPTH = 4;
  localparam logic [7:0] PAD = 8'hA5;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 0;
  logic [7:0] in_data = 0;
  logic [15:0] out_ab;
  logic out_pad, out_last;
  logic [2:0] level;
`ifdef AB_PACKER_PARITY_EN
  logic [1:0] out_par;
`endif
  ab_pair_packer #(.DEPTH(DEPTH), .PAD_BYTE(PAD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_ab(out_ab),
    .out_pad(out_pad), .out_last(out_last),
`ifdef AB_PACKER_PARITY_EN
    .out_par(out_par),
`endif
    .level(level)
  );
  always #5 clk = ~clk;

  typedef struct {logic [7:0] a, b; logic pad, last;} exp_t;
  typedef struct {logic [7:0] d; logic l; logic p; exp_t e;} vec_t;
  exp_t q[$];
  int pass_n = 0, tot_n = 0, pop_n = 0;
  logic st_m = 0;
  logic [7:0] a_m = 0;

  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%h exp=%h", n, got, exp);
  endfunction

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      pop_n++;
      if (q.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_pop got=%h exp=none", out_ab);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pair", {14'd0, out_ab, out_pad, out_last}, {14'd0, e.a, e.b, e.pad, e.last});
`ifdef AB_PACKER_PARITY_EN
        chk("par", {30'd0, out_par}, {30'd0, ^e.b, ^e.a});
`endif
      end
    end

  task automatic drive(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    if (!st_m) begin
      if (l) q.push_back('{a: d, b: PAD, pad: 1, last: 1});
      else begin a_m = d; st_m = 1; end
    end else begin
      q.push_back('{a: a_m, b: d, pad: 0, last: l});
      st_m = 0;
    end
    drive(d, l);
  endtask

  vec_t vecs[9];
  initial begin
    vecs[0] = '{8'h01, 0, 0, '{0, 0, 0, 0}};
    vecs[1] = '{8'h02, 0, 1, '{8'h01, 8'h02, 0, 0}};
    vecs[2] = '{8'h03, 0, 0, '{0, 0, 0, 0}};
    vecs[3] = '{8'h04, 1, 1, '{8'h03, 8'h04, 0, 1}};
    vecs[4] = '{8'h0A, 0, 0, '{0, 0, 0, 0}};
    vecs[5] = '{8'h0B, 0, 1, '{8'h0A, 8'h0B, 0, 0}};
    vecs[6] = '{8'h0C, 1, 1, '{8'h0C, PAD, 1, 1}};
    vecs[7] = '{8'h03, 0, 0, '{0, 0, 0, 0}};
    vecs[8] = '{8'h07, 1, 1, '{8'h03, 8'h07, 0, 1}};
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ab", out_ab, 0);
    chk("rst_pad_last", {out_pad, out_last}, 0);
    chk("rst_level", level, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready, 1);
    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].p) q.push_back(vecs[i].e);
      drive(vecs[i].d, vecs[i].l);
    end
    repeat (4) @(posedge clk); #1;
    chk("table_drained", q.size(), 0);
    out_ready = 0;
    fork
      for (int i = 0; i < 2 * DEPTH + 2; i++) send(8'h10 + 8'(i), i == 2 * DEPTH + 1);
      begin
        repeat (25) @(negedge clk);
        chk("full_level", level, DEPTH);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    repeat (10) @(posedge clk); #1;
    chk("fill_drained", q.size(), 0);
    out_ready = 0;
    send(8'h20, 0);
    send(8'h21, 0);
    chk("prime_level", level, 1);
    for (int i = 0; i < 32; i++) begin
      out_ready = 0;
      send(8'h40 + 8'(2 * i), 0);
      out_ready = 1;
      send(8'h41 + 8'(2 * i), i == 31);
      chk("steady_level", level, 1);
    end
    repeat (4) @(posedge clk); #1;
    chk("wrap_drained", q.size(), 0);
    out_ready = 0;
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 0);
    chk("pre_rst_level", level, 2);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_ab", out_ab, 0);
    chk("mid_rst_pad_last", {out_pad, out_last}, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    q.delete();
    st_m = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    out_ready = 1;
    begin
      int p0;
      p0 = pop_n;
      send(8'h05, 0);
      send(8'h06, 1);
      repeat (6) @(posedge clk); #1;
      chk("post_rst_pops", pop_n - p0, 1);
    end
    chk("post_rst_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
